// File: rtl/image_row_loader.sv
// Streams a raster image in and writes it, one zero-padded row per address,
// into the row RAM used by the convolution control stage.
module image_row_loader #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 128,
    parameter int IMG_H = 128
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [PIX_W-1:0]             pix_in,
    input  logic                         pix_valid,
    output logic                         pix_ready,
    output logic                         wr_en,
    output logic [7:0]                   wr_addr,
    output logic [(IMG_W+2)*PIX_W-1:0]   wr_data,
    output logic                         busy,
    output logic                         load_done
);

    localparam int              ROW_BITS = (IMG_W + 2) * PIX_W;
    localparam int              COL_W    = $clog2(IMG_W + 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
    localparam logic [7:0]      LAST_ROW = 8'(IMG_H - 1);
    localparam logic [7:0]      BOT_ADDR = 8'(IMG_H + 1);

    typedef enum logic [2:0] {
        IDLE,
        TOP_PAD,
        FILL,
        WRITE,
        BOT_PAD,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [7:0]           row_q, row_d;
    logic [COL_W-1:0]     col_q, col_d;
    logic                 wr_en_q, wr_en_d;
    logic [7:0]           wr_addr_q, wr_addr_d;
    logic [ROW_BITS-1:0]  wr_data_q, wr_data_d;
    logic                 busy_q, busy_d;
    logic                 load_done_q, load_done_d;
    logic                 accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            busy_q      <= 1'b0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            busy_q      <= busy_d;
            load_done_q <= load_done_d;
        end
    end

    // The write-data register doubles as the row assembly buffer; its value
    // only matters in the cycles where wr_en is high.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        wr_data_d = wr_data_q;
        accept    = (state_q == FILL) && pix_valid;

        for (int c = 0; c < IMG_W; c++) begin
            if (accept && col_q == COL_W'(c)) begin
                wr_data_d[(IMG_W - c) * PIX_W +: PIX_W] = pix_in;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = TOP_PAD;
                    row_d     = '0;
                    col_d     = '0;
                    wr_data_d = '0;
                end
            end
            TOP_PAD: state_d = FILL;
            FILL: begin
                if (accept) begin
                    if (col_q == LAST_COL) begin
                        col_d   = '0;
                        state_d = WRITE;
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            WRITE: begin
                if (row_q < LAST_ROW) begin
                    row_d   = row_q + 8'd1;
                    state_d = FILL;
                end else begin
                    state_d   = BOT_PAD;
                    wr_data_d = '0;
                end
            end
            BOT_PAD: state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Border columns stay zero regardless of what the buffer held.
        wr_data_d[ROW_BITS-1 -: PIX_W] = '0;
        wr_data_d[PIX_W-1:0]           = '0;
    end

    // Registered outputs are decoded from the next state so they line up
    // with the state register in the cycle they describe.
    always_comb begin
        wr_en_d     = 1'b0;
        wr_addr_d   = '0;
        busy_d      = (state_d != IDLE);
        load_done_d = (state_d == DONE);
        case (state_d)
            TOP_PAD: begin
                wr_en_d   = 1'b1;
                wr_addr_d = '0;
            end
            WRITE: begin
                wr_en_d   = 1'b1;
                wr_addr_d = row_d + 8'd1;
            end
            BOT_PAD: begin
                wr_en_d   = 1'b1;
                wr_addr_d = BOT_ADDR;
            end
            default: begin
                wr_en_d   = 1'b0;
                wr_addr_d = '0;
            end
        endcase
    end

    assign pix_ready = (state_q == FILL);
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = busy_q;
    assign load_done = load_done_q;

endmodule

// File: tb/tb_image_row_loader.sv
// Bench for image_row_loader: drives ramp frames and checks every cycle
// against an image model computed directly from pixel positions.
module tb_image_row_loader;

    localparam int P         = 8;
    localparam int W         = 128;
    localparam int H         = 128;
    localparam int DW        = (W + 2) * P;
    localparam int FRAME_CYC = 1 + H * (W + 1) + 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [P-1:0]  pix_in;
    logic          pix_valid;
    logic          pix_ready;
    logic          wr_en;
    logic [7:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          load_done;

    always #5 clk = ~clk;

    image_row_loader #(.PIX_W(P), .IMG_W(W), .IMG_H(H)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .load_done (load_done)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int exp_addr, wr_cnt, done_cnt, top_cyc, done_cyc;
    logic [DW-1:0] ram     [0:H+1];
    logic [DW-1:0] ram_ref [0:H+1];

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Padded row at RAM address a: image row a-1 holds the ramp (r*W+c) mod 256.
    function automatic logic [DW-1:0] exp_row(input int a);
        logic [DW-1:0] r;
        r = '0;
        if (a >= 1 && a <= H) begin
            for (int c = 0; c < W; c++) begin
                r[(W + 2 - (c + 1)) * P - 1 -: P] = P'(((a - 1) * W + c) % 256);
            end
        end
        return r;
    endfunction

    function automatic logic [P-1:0] col_of(input logic [DW-1:0] row, input int pc);
        return row[(W + 2 - pc) * P - 1 -: P];
    endfunction

    task automatic frame_reset();
        exp_addr = 0;
        wr_cnt   = 0;
        done_cnt = 0;
        top_cyc  = -1;
        done_cyc = -1;
    endtask

    // Advance to the next falling edge and compare all outputs against the model.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (!reset) begin
            if (wr_en) begin
                check("wr_addr_seq", DW'(wr_addr), DW'(exp_addr));
                check("wr_data_row", wr_data, exp_row(exp_addr));
                if (exp_addr == 0) top_cyc = cyc;
                if (int'(wr_addr) <= H + 1) ram[wr_addr] = wr_data;
                exp_addr++;
                wr_cnt++;
            end else begin
                check("wr_addr_idle", DW'(wr_addr), '0);
            end
            check("ready_during_write", DW'(pix_ready & wr_en), '0);
            if (load_done) begin
                check("done_after_last_row", DW'(exp_addr), DW'(H + 2));
                check("busy_at_done", DW'(busy), DW'(1));
                done_cnt++;
                done_cyc = cyc;
            end
        end
    endtask

    task automatic check_outputs_zero(input string nm);
        check({nm, "_wr_en"}, DW'(wr_en), '0);
        check({nm, "_wr_addr"}, DW'(wr_addr), '0);
        check({nm, "_wr_data"}, wr_data, '0);
        check({nm, "_busy"}, DW'(busy), '0);
        check({nm, "_load_done"}, DW'(load_done), '0);
        check({nm, "_pix_ready"}, DW'(pix_ready), '0);
    endtask

    task automatic run_frame(input bit toggle, input bit mid_start, input bit abort);
        int idx;
        bit last_acc, tog, seen_done, aborted;
        idx = 0; last_acc = 0; tog = 1; seen_done = 0; aborted = 0;
        frame_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 60000 && !seen_done && !aborted; k++) begin
            tick();
            if (last_acc) idx++;
            pix_valid = toggle ? tog : 1'b1;
            tog       = ~tog;
            // Offer 0xFF whenever the loader is not ready; it must never be stored.
            pix_in    = pix_ready ? P'(idx % 256) : 8'hFF;
            last_acc  = pix_valid && pix_ready;
            start     = mid_start && (k == 2000);
            if (load_done) seen_done = 1;
            if (abort && idx == 50 * W + 20) begin
                #2 reset = 1'b1;
                #1 check_outputs_zero("async_reset");
                tick();
                tick();
                reset   = 1'b0;
                aborted = 1;
            end
        end
        pix_valid = 1'b0;
        start     = 1'b0;
        check("frame_completed", DW'(seen_done || aborted), DW'(1));
        if (!abort) begin
            tick();
            check("busy_after_done", DW'(busy), '0);
            check("load_done_pulse", DW'(load_done), '0);
            check("load_done_count", DW'(done_cnt), DW'(1));
            check("write_count", DW'(wr_cnt), DW'(H + 2));
        end
        $display("[TB] frame toggle=%0d mid_start=%0d abort=%0d writes=%0d done=%0d cycles=%0d",
                 toggle, mid_start, abort, wr_cnt, done_cnt, done_cyc - top_cyc + 1);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        pix_valid = 1'b0;
        pix_in    = '0;
        tick();
        tick();
        check_outputs_zero("reset_state");
        reset = 1'b0;
        tick();
        tick();
        check("idle_busy", DW'(busy), '0);

        // Continuous ramp with a stray start pulse mid-frame.
        run_frame(1'b0, 1'b1, 1'b0);
        check("frame_cycles", DW'(done_cyc - top_cyc + 1), DW'(FRAME_CYC));
        for (int a = 0; a < H + 2; a++) ram_ref[a] = ram[a];
        check("pin_row0_zero", ram_ref[0], '0);
        check("pin_row129_zero", ram_ref[H + 1], '0);
        check("pin_r1_c1", DW'(col_of(ram_ref[1], 1)), DW'(8'h00));
        check("pin_r1_c128", DW'(col_of(ram_ref[1], W)), DW'(8'h7F));
        check("pin_r2_c1", DW'(col_of(ram_ref[2], 1)), DW'(8'h80));
        check("pin_r128_c128", DW'(col_of(ram_ref[H], W)), DW'(8'hFF));
        for (int a = 0; a < H + 2; a++) begin
            check("pad_col0", DW'(col_of(ram_ref[a], 0)), '0);
            check("pad_col129", DW'(col_of(ram_ref[a], W + 1)), '0);
        end
        tick();

        // Alternating pix_valid must produce the identical image.
        run_frame(1'b1, 1'b0, 1'b0);
        for (int a = 0; a < H + 2; a++) check("toggle_image", ram[a], ram_ref[a]);
        tick();

        // Reset during row 50, then a clean frame from address 0.
        run_frame(1'b0, 1'b0, 1'b1);
        tick();
        tick();
        check("post_abort_busy", DW'(busy), '0);
        run_frame(1'b0, 1'b0, 1'b0);
        check("restart_cycles", DW'(done_cyc - top_cyc + 1), DW'(FRAME_CYC));
        for (int a = 0; a < H + 2; a++) check("restart_image", ram[a], ram_ref[a]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/image_row_loader.md
IMAGE_ROW_LOADER -- requirements
Module: image_row_loader

Interface
REQ-001 SHALL have parameter PIX_W, default 8, bits per pixel.
REQ-002 SHALL have parameter IMG_W, default 128, unpadded image width in pixels.
REQ-003 SHALL have parameter IMG_H, default 128, unpadded image height in rows.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle request to load a new frame.
REQ-007 SHALL have port pix_in  input  PIX_W  raster-order pixel, row 0 column 0 first.
REQ-008 SHALL have port pix_valid  input  1  pix_in valid this cycle.
REQ-009 SHALL have port pix_ready  output  1  loader accepts pix_in this cycle.
REQ-010 SHALL have port wr_en  output  1  row-RAM write strobe.
REQ-011 SHALL have port wr_addr  output  8  row-RAM address, 0..IMG_H+1.
REQ-012 SHALL have port wr_data  output  (IMG_W+2)*PIX_W (1040)  padded row.
REQ-013 SHALL have port busy  output  1  frame load in progress.
REQ-014 SHALL have port load_done  output  1  one-cycle pulse after the last row write.

Function
REQ-015 SHALL write a zero-padded (IMG_H+2) x (IMG_W+2) frame into the row RAM, one row per address, consumed by the convolution control stage.
REQ-016 SHALL pack padded column c at wr_data[(IMG_W+2-c)*PIX_W-1 -: PIX_W]; column 0 in the MSBs.
REQ-017 SHALL implement FSM states IDLE, TOP_PAD, FILL, WRITE, BOT_PAD, DONE.
REQ-018 IDLE: start=1 -> TOP_PAD next cycle, busy=1; start ignored in every other state.
REQ-019 TOP_PAD: wr_en=1, wr_addr=0, wr_data=0 for exactly one cycle -> FILL.
REQ-020 FILL: pix_ready=1; each cycle with pix_valid&pix_ready stores pix_in in padded column (col+1) and increments col; no transfer -> no state change.
REQ-021 FILL -> WRITE on the cycle the IMG_W-th pixel of the row is accepted.
REQ-022 WRITE: pix_ready=0, wr_en=1, wr_addr=row+1, wr_data=assembled row with columns 0 and IMG_W+1 forced to 0, for one cycle.
REQ-023 WRITE -> FILL with col=0, row+1 when row < IMG_H-1; else -> BOT_PAD.
REQ-024 BOT_PAD: wr_en=1, wr_addr=IMG_H+1, wr_data=0 for one cycle -> DONE.
REQ-025 DONE: load_done=1, busy=1 for one cycle -> IDLE; busy=0 from the following cycle.
REQ-026 wr_en, wr_addr, wr_data, busy and load_done SHALL be registered outputs; pix_ready SHALL be decoded from the state register only.
REQ-027 With pix_valid held 1, a frame SHALL take 1 + IMG_H*(IMG_W+1) + 2 cycles from TOP_PAD to DONE inclusive (16515 at defaults).
REQ-028 pix_valid deassertion in FILL SHALL stall without losing or duplicating pixels.
REQ-029 pix_in SHALL be ignored whenever pix_ready=0.
REQ-030 wr_addr SHALL be 0 whenever wr_en=0.

Reset
REQ-031 reset=1 SHALL immediately force state IDLE, row=0, col=0, row register=0, and all outputs 0, independent of clk.
REQ-032 reset asserted mid-frame SHALL discard the partial frame; the next start SHALL begin again at TOP_PAD address 0.

Verification
REQ-033 Reset, then start with a continuous ramp pix_in = (r*IMG_W+c) mod 256 -> writes at addresses 0..129 in order; address 0 and 129 all zero; row 1 column 1 = 0x00, column 128 = 0x7F; load_done exactly once, 16515 cycles after TOP_PAD.
REQ-034 pix_valid toggling 1,0,1,0 throughout -> identical RAM image to REQ-033; no wr_en during stalls except row writes.
REQ-035 pix_valid=1 in the WRITE cycle with pix_in=0xFF -> pixel not consumed; next row column 1 holds the next stream pixel.
REQ-036 start pulsed again mid-frame -> ignored; address sequence unchanged.
REQ-037 reset pulsed during row 50 FILL -> outputs 0 asynchronously; subsequent start rewrites from address 0 with correct data.
REQ-038 Every write -> padded columns 0 and 129 equal 0x00 in all 130 rows.
